sync_fifo_fwft: RTL and testbench
=================================

# sync_fifo_fwft

Parametrised synchronous first-word-fall-through FIFO. It is the next generation of the team's 16-deep single-clock FIFO and adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between streaming producers and consumers in the same clock domain. Storage is a 2**DEPTH_LOG2-entry array followed by one registered output stage, so total capacity is DEPTH+1 words.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH_LOG2, 4: log2 of array depth; DEPTH = 2**DEPTH_LOG2; legal range 1..12.
- AFULL_THRESH, DEPTH-1: almost_full asserts when level >= AFULL_THRESH.
- AEMPTY_THRESH, 1: almost_empty asserts when level <= AEMPTY_THRESH.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; overrides enq and deq.
- data_in  in  WIDTH  write data.
- enq  in  1  write request.
- full  out  1  array holds DEPTH words; enq ignored.
- almost_full  out  1  level >= AFULL_THRESH.
- data_out  out  WIDTH  head word; registered.
- valid_out  out  1  data_out holds a valid word; registered.
- deq  in  1  consumer takes data_out this cycle.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- level  out  DEPTH_LOG2+1  words held, array count + valid_out (0..DEPTH+1).
- overflow  out  1  sticky: enq seen while full.
- underflow  out  1  sticky: deq seen while !valid_out.

## Operation
- Pointers head and tail are DEPTH_LOG2+1 bits wide. The MSB is a wrap bit. Array count = tail - head, taken modulo 2**(DEPTH_LOG2+1).
- full = (count == DEPTH). It is decoded combinationally from the registered pointers only, with no enq/deq path.
- Write: when enq && !full, data_in goes to mem[tail[DEPTH_LOG2-1:0]] and tail increments.
- enq while full: the word is dropped, tail is unchanged, and overflow sets.
- Deq in the same cycle does not make room for a write while full. There is no pass-through.
- Output stage refills when (!valid_out || deq) and count != 0: data_out <= mem[head], head increments, valid_out <= 1.
- deq with count == 0 and valid_out: valid_out <= 0 and data_out holds its value.
- deq while !valid_out: ignored, and underflow sets.
- level, almost_full and almost_empty are combinational from registered state.
- clear: head, tail and data_out go to 0, and valid_out, overflow and underflow go to 0. clear beats a simultaneous enq or deq, and both are discarded.
- Reset (rst_n low, at any time including mid-transfer) produces the same state as clear, applied asynchronously. Array contents are not reset.
- Reset values: full 0, almost_full 0 (1 if AFULL_THRESH == 0), almost_empty 1, valid_out 0, data_out 0, level 0, overflow 0, underflow 0.

## Timing
- Enq-to-valid latency into an empty FIFO: 2 cycles. The write lands at edge N and valid_out rises at edge N+1.
- Sustained throughput is 1 word/cycle with enq and deq both high and 0 < count < DEPTH.
- full deasserts one cycle after the first deq that drains an array slot.
- The deq handshake completes on any edge where valid_out && deq.
- Pointer wrap at DEPTH must be seamless, with no bubble and no lost word.
- rst_n deassertion must be synchronised externally. Behaviour in the first cycle after release is already idle.

## Structure
- Shared package fifo_pkg holds:
  - a ptr_t width function of DEPTH_LOG2;
  - an occupancy type sized DEPTH_LOG2+1;
  - a threshold-legality check constant that fails elaboration if AFULL_THRESH > DEPTH+1 or AEMPTY_THRESH > DEPTH+1.
- Sub-module fifo_mem holds the storage: a DEPTH x WIDTH array with synchronous write and combinational read, no reset.
- sync_fifo_fwft holds the pointers, the output stage, the flags and the counters.

## Test plan
All scenarios use WIDTH=8, DEPTH_LOG2=2 (DEPTH 4, capacity 5), AFULL_THRESH=4 and AEMPTY_THRESH=1.
- Reset, then one enq of 0xA5 -> valid_out=1 and data_out=0xA5 two edges later, level=1, almost_empty=1.
- Enq 0x01..0x06 with deq=0 -> full=1 after the fifth accepted word, 0x06 dropped, overflow=1, level=5, almost_full=1. Then deq 5 times -> data 0x01..0x05 in order, valid_out=0, level=0.
- Continuous enq+deq of a counting stream for 20 words (pointers wrap 5 times) -> output stream identical, no bubbles after the first 2 cycles.
- Full FIFO with enq=1 and deq=1 in the same cycle -> 0x01 consumed, new word dropped, overflow=1, level=4 next cycle.
- deq=1 on an empty FIFO -> underflow=1, level stays 0. A later clear -> underflow=0.
- Three words held, then clear=1 with enq=1 -> level=0, valid_out=0, data_out=0, word discarded. rst_n pulsed low mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared helpers for the FWFT FIFO family: pointer sizing, occupancy type and
// an elaboration-time sanity check on the threshold parameters.
package fifo_pkg;

    localparam int MAX_DEPTH_LOG2 = 12;

    // Widest occupancy any legal instance can report; thresholds compare in this domain.
    typedef logic [MAX_DEPTH_LOG2:0] occ_t;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic bit thresh_ok(input int depth_log2, input int afull, input int aempty);
        return (depth_log2 >= 1) && (depth_log2 <= MAX_DEPTH_LOG2) &&
               (afull >= 0) && (aempty >= 0) &&
               (afull <= (1 << depth_log2) + 1) && (aempty <= (1 << depth_log2) + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer bundle for sync_fifo_fwft; the FIFO takes the slave side.
interface sync_fifo_fwft_if
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
);
    logic                         clear;
    logic [WIDTH-1:0]             data_in;
    logic                         enq;
    logic                         full;
    logic                         almost_full;
    logic [WIDTH-1:0]             data_out;
    logic                         valid_out;
    logic                         deq;
    logic                         almost_empty;
    logic [ptr_w(DEPTH_LOG2)-1:0] level;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output clear, data_in, enq, deq,
        input  full, almost_full, data_out, valid_out, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  clear, data_in, enq, deq,
        output full, almost_full, data_out, valid_out, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft_mem.sv
// FIFO storage: synchronous write, combinational read, contents never reset.
module fifo_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: 2**DEPTH_LOG2-entry array plus one registered
// output stage, with level, threshold flags, flush and sticky error flags.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH_LOG2    = 4,
    parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_fwft_if.slave  bus
);
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int PW        = ptr_w(DEPTH_LOG2);
    localparam bit THRESH_OK = thresh_ok(DEPTH_LOG2, AFULL_THRESH, AEMPTY_THRESH);

    typedef logic [PW-1:0] ptr_t;

    generate
        if (!THRESH_OK) begin : g_bad_cfg
            $error("sync_fifo_fwft: illegal DEPTH_LOG2 or threshold parameters");
        end
    endgenerate

    ptr_t             head, tail, count, level;
    logic [WIDTH-1:0] rd_data, data_out_q;
    logic             valid_q, ovf_q, udf_q;
    logic             full, wr_en, refill;

    // full only looks at registered pointers: a same-cycle deq never frees a slot for enq.
    assign count  = tail - head;
    assign full   = (count == ptr_t'(DEPTH));
    assign wr_en  = bus.enq && !full && !bus.clear;
    // Refill reads the array as it stood before this edge, so a write is never passed straight through.
    assign refill = (!valid_q || bus.deq) && (count != '0);

    fifo_mem #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail[DEPTH_LOG2-1:0]),
        .wdata (bus.data_in),
        .raddr (head[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else if (bus.clear) begin
            head       <= '0;
            tail       <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            if (wr_en)              tail  <= tail + ptr_t'(1);
            if (bus.enq && full)    ovf_q <= 1'b1;
            if (bus.deq && !valid_q) udf_q <= 1'b1;
            if (refill) begin
                data_out_q <= rd_data;
                head       <= head + ptr_t'(1);
                valid_q    <= 1'b1;
            end else if (bus.deq && valid_q) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign level            = count + ptr_t'(valid_q);
    assign bus.full         = full;
    assign bus.level        = level;
    assign bus.almost_full  = occ_t'(level) >= occ_t'(AFULL_THRESH);
    assign bus.almost_empty = occ_t'(level) <= occ_t'(AEMPTY_THRESH);
    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: directed vector table, hand sequences for streaming
// and async reset, then random traffic against a queue-based reference model.
module tb_sync_fifo_fwft;
    localparam int W = 8, DL2 = 2, DEPTH = 4, AF = 4, AE = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, errors = 0;

    sync_fifo_fwft_if #(.WIDTH(W), .DEPTH_LOG2(DL2)) bus ();

    sync_fifo_fwft #(.WIDTH(W), .DEPTH_LOG2(DL2), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [2:0] lvl;
        logic       full, af, ae, ovf, udf;
    } obs_t;

    typedef struct {
        logic clr, enq, deq; logic [7:0] din;
        logic v; logic [7:0] d; int lvl; logic ovf, udf;
    } vec_t;

    // Flags follow from the occupancy rules: array words = level - output-stage word.
    function automatic obs_t mk(logic v, logic [7:0] d, int lvl, logic ovf, logic udf);
        obs_t o;
        o.v = v; o.d = d; o.lvl = 3'(lvl);
        o.full = ((lvl - int'(v)) == DEPTH);
        o.af = (lvl >= AF);
        o.ae = (lvl <= AE);
        o.ovf = ovf; o.udf = udf;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.v = bus.valid_out; o.d = bus.data_out; o.lvl = bus.level;
        o.full = bus.full; o.af = bus.almost_full; o.ae = bus.almost_empty;
        o.ovf = bus.overflow; o.udf = bus.underflow;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b d=%h lvl=%0d full=%0b af=%0b ae=%0b ovf=%0b udf=%0b, want v=%0b d=%h lvl=%0d full=%0b af=%0b ae=%0b ovf=%0b udf=%0b",
                     name, act.v, act.d, act.lvl, act.full, act.af, act.ae, act.ovf, act.udf,
                     exp.v, exp.d, exp.lvl, exp.full, exp.af, exp.ae, exp.ovf, exp.udf);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic e, input logic d, input logic [7:0] din);
        bus.clear = c; bus.enq = e; bus.deq = d; bus.data_in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one queue holding every word in the FIFO, front word
    // visible on the output once it has spent a cycle inside.
    logic [7:0] mq[$];
    bit         mv, movf, mudf;
    logic [7:0] md;

    task automatic model_step(input bit c, input bit e, input bit d, input logic [7:0] din);
        int arr;
        bit acc;
        if (c) begin
            mq.delete(); mv = 0; md = 8'h00; movf = 0; mudf = 0;
        end else begin
            arr = mq.size() - int'(mv);
            acc = e && (arr < DEPTH);
            if (e && !acc) movf = 1;
            if (d && !mv) mudf = 1;
            if (d && mv) begin
                void'(mq.pop_front());
                mv = 0;
            end
            if (!mv && mq.size() > 0) begin
                mv = 1;
                md = mq[0];
            end
            if (acc) mq.push_back(din);
        end
    endtask

    vec_t tbl[$];
    int   got[$];
    int   bubbles;

    initial begin
        // clr enq deq din | v d lvl ovf udf
        tbl.push_back('{0,1,0,8'hA5, 0,8'h00,1,0,0});
        tbl.push_back('{0,0,0,8'h00, 1,8'hA5,1,0,0});
        tbl.push_back('{0,0,1,8'h00, 0,8'hA5,0,0,0});
        tbl.push_back('{0,1,0,8'h01, 0,8'hA5,1,0,0});
        tbl.push_back('{0,1,0,8'h02, 1,8'h01,2,0,0});
        tbl.push_back('{0,1,0,8'h03, 1,8'h01,3,0,0});
        tbl.push_back('{0,1,0,8'h04, 1,8'h01,4,0,0});
        tbl.push_back('{0,1,0,8'h05, 1,8'h01,5,0,0});
        tbl.push_back('{0,1,0,8'h06, 1,8'h01,5,1,0});
        tbl.push_back('{0,0,1,8'h00, 1,8'h02,4,1,0});
        tbl.push_back('{0,0,1,8'h00, 1,8'h03,3,1,0});
        tbl.push_back('{0,0,1,8'h00, 1,8'h04,2,1,0});
        tbl.push_back('{0,0,1,8'h00, 1,8'h05,1,1,0});
        tbl.push_back('{0,0,1,8'h00, 0,8'h05,0,1,0});
        tbl.push_back('{1,0,0,8'h00, 0,8'h00,0,0,0});
        tbl.push_back('{0,1,0,8'h01, 0,8'h00,1,0,0});
        tbl.push_back('{0,1,0,8'h02, 1,8'h01,2,0,0});
        tbl.push_back('{0,1,0,8'h03, 1,8'h01,3,0,0});
        tbl.push_back('{0,1,0,8'h04, 1,8'h01,4,0,0});
        tbl.push_back('{0,1,0,8'h05, 1,8'h01,5,0,0});
        tbl.push_back('{0,1,1,8'h07, 1,8'h02,4,1,0});
        tbl.push_back('{1,0,0,8'h00, 0,8'h00,0,0,0});
        tbl.push_back('{0,0,1,8'h00, 0,8'h00,0,0,1});
        tbl.push_back('{0,0,0,8'h00, 0,8'h00,0,0,1});
        tbl.push_back('{1,0,0,8'h00, 0,8'h00,0,0,0});
        tbl.push_back('{0,1,0,8'h11, 0,8'h00,1,0,0});
        tbl.push_back('{0,1,0,8'h22, 1,8'h11,2,0,0});
        tbl.push_back('{0,1,0,8'h33, 1,8'h11,3,0,0});
        tbl.push_back('{1,1,0,8'h44, 0,8'h00,0,0,0});
        tbl.push_back('{1,1,1,8'h55, 0,8'h00,0,0,0});
        tbl.push_back('{0,0,0,8'h00, 0,8'h00,0,0,0});

        drive(0, 0, 0, 8'h00);
        #12;
        check("reset_state", mk(0, 8'h00, 0, 0, 0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_after_release", mk(0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].enq, tbl[i].deq, tbl[i].din);
            tick();
            check($sformatf("vec%0d", i), mk(tbl[i].v, tbl[i].d, tbl[i].lvl, tbl[i].ovf, tbl[i].udf));
        end

        // Back-to-back stream through an empty FIFO; consumer takes whatever is valid.
        bubbles = 0;
        for (int k = 0; k < 24; k++) begin
            bus.clear   = 1'b0;
            bus.enq     = (k < 20);
            bus.data_in = 8'(8'h40 + k);
            bus.deq     = bus.valid_out;
            if (bus.valid_out && bus.deq) got.push_back(int'(bus.data_out));
            tick();
            if (k >= 1 && k <= 20 && !bus.valid_out) bubbles++;
        end
        check_val("stream_count", got.size(), 20);
        foreach (got[i]) check_val($sformatf("stream_word%0d", i), got[i], 8'h40 + i);
        check_val("stream_bubbles", bubbles, 0);
        check_val("stream_no_underflow", int'(bus.underflow), 0);

        // Async reset with words in flight must act without a clock edge.
        drive(0, 1, 0, 8'h77);
        tick(); tick(); tick();
        check("pre_reset_fill", mk(1, 8'h77, 3, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_immediate", mk(0, 8'h00, 0, 0, 0));
        drive(0, 1, 1, 8'h99);
        tick();
        check("reset_held", mk(0, 8'h00, 0, 0, 0));
        drive(0, 0, 0, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_reset_idle", mk(0, 8'h00, 0, 0, 0));

        // Random traffic against the queue model, starting from a flush.
        drive(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 8'h00);
        tick();
        check("rand_start", mk(mv, md, mq.size(), movf, mudf));
        for (int n = 0; n < 400; n++) begin
            bit c, e, d;
            logic [7:0] din;
            c   = ($urandom_range(0, 99) < 3);
            e   = ($urandom_range(0, 99) < 55);
            d   = ($urandom_range(0, 99) < 50);
            din = 8'($urandom);
            drive(c, e, d, din);
            model_step(c, e, d, din);
            tick();
            check($sformatf("rand%0d", n), mk(mv, md, mq.size(), movf, mudf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
